// File: rtl/cpu_bus_responder.sv
// 68030 bus responder for the ReSDMAC register file: decodes CPU cycles under CS_, strobes the
// register bank and terminates with DSACKx_. Define STERM_RESPONDER_EN for synchronous long reads.
module cpu_bus_responder #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 5
) (
    input  logic              CLK,
    input  logic              RST_,
    input  logic              CS_,
    input  logic              AS_,
    input  logic              DS_,
    input  logic              R_W,
    input  logic [1:0]        SIZ,
    input  logic [ADDR_W+1:0] A,
    output logic [ADDR_W-1:0] REG_ADDR,
    output logic [3:0]        REG_BE,
    output logic              REG_RD,
    output logic              REG_WR,
    output logic              DATA_OE,
    output logic              DSACK0_,
    output logic              DSACK1_,
    output logic              STERM_
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_ACK,
        S_HOLD
    } state_t;

    localparam logic       WS_ZERO = (WAIT_STATES == 0);
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_rw;
    logic              r_sterm_cyc;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic              r_rd;
    logic              r_wr;
    logic              r_oe;
    logic              r_dsack_n;
    logic              r_sterm_n;

    logic w_ack_ready;
    logic w_enter_ack;
    logic w_sterm_sel;

    // Top n lanes of a full long, shifted down by the lane offset; overrun falls off below D7:0.
    function automatic logic [3:0] lane_enables(input logic [1:0] siz, input logic [1:0] off);
        logic [2:0] n;
        logic [3:0] m;
        n = (siz == 2'b00) ? 3'd4 : {1'b0, siz};
        m = 4'b1111 << (3'd4 - n);
        return m >> off;
    endfunction

`ifdef STERM_RESPONDER_EN
    assign w_sterm_sel = R_W & (SIZ == 2'b00) & (A[1:0] == 2'b00);
`else
    assign w_sterm_sel = 1'b0;
`endif

    // Writes may only terminate once the CPU has put data on the bus (DS_ low).
    assign w_ack_ready = r_rw | ~DS_;
    assign w_enter_ack = ~AS_ & w_ack_ready &
                         (((r_state == S_DECODE) & WS_ZERO) |
                          ((r_state == S_WAIT) & (r_cnt == 3'd0)));

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_rw        <= 1'b1;
            r_sterm_cyc <= 1'b0;
            r_addr      <= '0;
            r_be        <= 4'b0000;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_oe        <= 1'b0;
            r_dsack_n   <= 1'b1;
            r_sterm_n   <= 1'b1;
        end else begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
            if (w_enter_ack) begin
                r_state <= S_ACK;
                r_wr    <= ~r_rw;
                if (r_sterm_cyc) r_sterm_n <= 1'b0;
                else             r_dsack_n <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!AS_ && !CS_) begin
                            r_state     <= S_DECODE;
                            r_addr      <= A[ADDR_W+1:2];
                            r_be        <= lane_enables(SIZ, A[1:0]);
                            r_rw        <= R_W;
                            r_sterm_cyc <= w_sterm_sel;
                            r_rd        <= R_W;
                            r_oe        <= R_W;
                        end
                    end
                    S_DECODE: begin
                        if (AS_) begin
                            r_state <= S_IDLE;
                            r_oe    <= 1'b0;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WS_LOAD;
                        end
                    end
                    S_WAIT: begin
                        if (AS_) begin
                            r_state <= S_IDLE;
                            r_oe    <= 1'b0;
                        end else if (r_cnt != 3'd0) begin
                            r_cnt <= r_cnt - 3'd1;
                        end
                    end
                    S_ACK: begin
                        r_state   <= S_HOLD;
                        r_sterm_n <= 1'b1;
                    end
                    S_HOLD: begin
                        if (AS_) begin
                            r_state   <= S_IDLE;
                            r_dsack_n <= 1'b1;
                            r_oe      <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign REG_ADDR = r_addr;
    assign REG_BE   = r_be;
    assign REG_RD   = r_rd;
    assign REG_WR   = r_wr;
    assign DATA_OE  = r_oe;
    assign DSACK0_  = r_dsack_n;
    assign DSACK1_  = r_dsack_n;
    assign STERM_   = r_sterm_n;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench for cpu_bus_responder: drivers push expected strobes/acks, a negedge monitor pops them.
module tb_cpu_bus_responder;

    localparam int WS = 1;
    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RST_ = 1'b0;
    logic          CS_ = 1'b1;
    logic          AS_ = 1'b1;
    logic          DS_ = 1'b1;
    logic          R_W = 1'b1;
    logic [1:0]    SIZ = 2'b00;
    logic [AW+1:0] A = '0;
    logic [AW-1:0] REG_ADDR;
    logic [3:0]    REG_BE;
    logic          REG_RD, REG_WR, DATA_OE, DSACK0_, DSACK1_, STERM_;

    cpu_bus_responder #(.WAIT_STATES(WS), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST_(RST_), .CS_(CS_), .AS_(AS_), .DS_(DS_), .R_W(R_W), .SIZ(SIZ), .A(A),
        .REG_ADDR(REG_ADDR), .REG_BE(REG_BE), .REG_RD(REG_RD), .REG_WR(REG_WR),
        .DATA_OE(DATA_OE), .DSACK0_(DSACK0_), .DSACK1_(DSACK1_), .STERM_(STERM_)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { int cyc; bit wr; logic [AW-1:0] addr; logic [3:0] be; } strobe_t;
    typedef struct { int cyc; bit sterm; bit rd; } ack_t;
    strobe_t strobe_q[$];
    ack_t    ack_q[$];
    int      rel_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Lanes covered by an n-byte transfer starting at byte offset off; lane k drives BE[3-k].
    function automatic logic [3:0] model_be(input logic [1:0] siz, input logic [1:0] off);
        int n;
        logic [3:0] be;
        n = (siz == 2'b00) ? 4 : int'(siz);
        be = 4'b0000;
        for (int k = 0; k < 4; k++)
            if (k >= int'(off) && k < int'(off) + n) be[3-k] = 1'b1;
        return be;
    endfunction

    function automatic bit model_sterm(input bit rd, input logic [1:0] siz, input logic [1:0] off);
`ifdef STERM_RESPONDER_EN
        return rd && siz == 2'b00 && off == 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- monitor ----------------
    strobe_t m_s;
    ack_t    m_a;
    int      m_r;
    logic    m_ack_now;
    logic    p_ack = 1'b0, p_dsack = 1'b0, p_sterm = 1'b0;
    int      sterm_len = 0;

    always @(negedge CLK) begin
        if (!RST_) begin
            p_ack = 1'b0; p_dsack = 1'b0; p_sterm = 1'b0; sterm_len = 0;
        end else begin
            if (REG_RD || REG_WR) begin
                check("strobe_exclusive", {REG_RD, REG_WR} == 2'b11, 0);
                if (strobe_q.size() == 0) flag("strobe_unexpected");
                else begin
                    m_s = strobe_q.pop_front();
                    check("strobe_cycle", cyc, m_s.cyc);
                    check("strobe_is_write", REG_WR, m_s.wr);
                    check("reg_addr", REG_ADDR, m_s.addr);
                    check("reg_be", REG_BE, m_s.be);
                end
            end
            m_ack_now = !DSACK0_ || !DSACK1_ || !STERM_;
            if (m_ack_now && !p_ack) begin
                if (ack_q.size() == 0) flag("ack_unexpected");
                else begin
                    m_a = ack_q.pop_front();
                    check("ack_cycle", cyc, m_a.cyc);
                    check("ack_sterm", !STERM_, m_a.sterm);
                    check("ack_dsack_pair", {DSACK1_, DSACK0_}, m_a.sterm ? 2'b11 : 2'b00);
                    check("ack_data_oe", DATA_OE, m_a.rd);
                end
            end
            if (!STERM_) sterm_len++;
            else if (p_sterm) begin
                check("sterm_width", sterm_len, 1);
                sterm_len = 0;
            end
            if (DSACK0_ && p_dsack) begin
                if (rel_q.size() == 0) flag("release_unexpected");
                else begin
                    m_r = rel_q.pop_front();
                    check("release_cycle", cyc, m_r);
                    check("release_data_oe", DATA_OE, 0);
                end
            end
            p_ack = m_ack_now; p_dsack = !DSACK0_; p_sterm = !STERM_;
        end
    end

    // ---------------- drivers ----------------
    task automatic do_xfer(input bit rd, input logic [AW+1:0] addr, input logic [1:0] siz,
                           input int ds_dly, input int hold_extra, input bit rst_in_hold);
        int c, t0, ack_e, waited;
        bit st;
        strobe_t s;
        ack_t a;
        @(posedge CLK); #1;
        c = cyc; t0 = c + 1;
        CS_ = 1'b0; AS_ = 1'b0; R_W = rd; SIZ = siz; A = addr;
        DS_ = (rd || ds_dly == 0) ? 1'b0 : 1'b1;
        st = model_sterm(rd, siz, addr[1:0]);
        // Acks come WS+1 edges after decode, and a write also no earlier than DS_ being seen low.
        ack_e = t0 + 1 + WS;
        if (!rd && t0 + ds_dly > ack_e) ack_e = t0 + ds_dly;
        s.cyc = rd ? t0 : ack_e; s.wr = !rd; s.addr = addr[AW+1:2]; s.be = model_be(siz, addr[1:0]);
        strobe_q.push_back(s);
        a.cyc = ack_e; a.sterm = st; a.rd = rd;
        ack_q.push_back(a);
        waited = 0;
        while (DSACK0_ && STERM_ && waited < 40) begin
            @(posedge CLK); #1;
            waited++;
            if (waited == 1) CS_ = 1'($urandom_range(0, 1));
            if (!rd && waited == ds_dly) DS_ = 1'b0;
        end
        if (waited >= 40) begin
            flag("ack_timeout");
        end
        repeat (hold_extra) begin @(posedge CLK); #1; end
        @(posedge CLK); #1;
        if (rst_in_hold) begin
            #2 RST_ = 1'b0;
            #1;
            check("rst_dsack0", DSACK0_, 1);
            check("rst_dsack1", DSACK1_, 1);
            check("rst_data_oe", DATA_OE, 0);
            check("rst_reg_be", REG_BE, 0);
            AS_ = 1'b1; DS_ = 1'b1; CS_ = 1'b1;
            @(posedge CLK); #1;
            RST_ = 1'b1;
        end else begin
            AS_ = 1'b1; DS_ = 1'b1; CS_ = 1'b1;
            if (!st) rel_q.push_back(cyc + 1);
        end
    endtask

    task automatic do_abort(input int k);
        @(posedge CLK); #1;
        CS_ = 1'b0; AS_ = 1'b0; R_W = 1'b0; DS_ = 1'b1;
        SIZ = 2'($urandom_range(0, 3)); A = (AW+2)'($urandom);
        repeat (k) begin @(posedge CLK); #1; end
        AS_ = 1'b1; CS_ = 1'b1;
    endtask

    task automatic do_cs_high();
        @(posedge CLK); #1;
        CS_ = 1'b1; AS_ = 1'b0; DS_ = 1'b0; R_W = 1'($urandom_range(0, 1));
        A = (AW+2)'($urandom);
        repeat (3) begin @(posedge CLK); #1; end
        AS_ = 1'b1; DS_ = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("reset_dsack0", DSACK0_, 1);
        check("reset_dsack1", DSACK1_, 1);
        check("reset_sterm", STERM_, 1);
        check("reset_reg_rd", REG_RD, 0);
        check("reset_reg_wr", REG_WR, 0);
        check("reset_data_oe", DATA_OE, 0);
        check("reset_reg_addr", REG_ADDR, 0);
        check("reset_reg_be", REG_BE, 0);
        RST_ = 1'b1;

        do_xfer(1'b1, 7'h0C, 2'b00, 0, 1, 1'b0);
        do_xfer(1'b0, 7'h13, 2'b01, 4, 0, 1'b0);
        do_xfer(1'b1, 7'h0B, 2'b10, 0, 0, 1'b0);
        do_xfer(1'b0, 7'h05, 2'b11, 2, 0, 1'b0);
        do_abort(2);
        do_xfer(1'b0, 7'h26, 2'b10, 0, 1, 1'b0);
        do_abort(1);
        do_xfer(1'b1, 7'h40, 2'b00, 0, 2, 1'b0);
        do_xfer(1'b1, 7'h18, 2'b00, 0, 0, 1'b1);
        do_cs_high();
        do_xfer(1'b1, 7'h09, 2'b01, 0, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) do_abort(int'($urandom_range(1, 3)));
            else if (kind == 1) do_cs_high();
            else do_xfer(1'($urandom_range(0, 1)), (AW+2)'($urandom), 2'($urandom_range(0, 3)),
                         int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'b0);
        end

        repeat (5) @(posedge CLK);
        #1;
        check("strobe_queue_drained", strobe_q.size(), 0);
        check("ack_queue_drained", ack_q.size(), 0);
        check("release_queue_drained", rel_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
